// File: rtl/moving_sum_deconvolver_pkg.sv
// Shared widths and types for the moving-average family: the averager and its
// deconvolver must agree on window length and sample/sum widths.
package moving_average_types;

    localparam int N_DEFAULT        = 4;
    localparam int SAMPLE_W_DEFAULT = 8;
    localparam int SUM_W_DEFAULT    = SAMPLE_W_DEFAULT + $clog2(N_DEFAULT);

    typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;
    typedef logic signed [SUM_W_DEFAULT-1:0]    sum_t;
    typedef logic [$clog2(N_DEFAULT)-1:0]       ptr_t;

endpackage

// File: rtl/moving_sum_deconv_ring.sv
// N-entry sample history with a wrapping pointer. rd_data shows the entry at the
// pointer (x[n-N]) in the same cycle that adv overwrites it with x[n].
module moving_sum_deconv_ring #(
    parameter int N        = 4,
    parameter int SAMPLE_W = 8,
    localparam int PTR_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                       clk,
    input  logic                       flush,
    input  logic                       adv,
    input  logic signed [SAMPLE_W-1:0] wr_data,
    output logic signed [SAMPLE_W-1:0] rd_data
);

    logic signed [SAMPLE_W-1:0] hist [N];
    logic [PTR_W-1:0]           ptr;

    assign rd_data = hist[ptr];

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            ptr <= '0;
        end else if (adv) begin
            hist[ptr] <= wr_data;
            ptr       <= (ptr == PTR_W'(N - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/moving_sum_deconvolver.sv
// Recovers x[n] from a moving-window sum stream: x[n] = S[n] - S[n-1] + x[n-N].
// Handshake: a beat transfers on a rising edge where valid and ready are both 1;
// valid never depends on ready, and an offered beat stays stable until it transfers.
module moving_sum_deconvolver
    import moving_average_types::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    localparam int SUM_W   = SAMPLE_W + $clog2(N)
) (
    input  logic                       system1000,
    input  logic                       system1000_rst,
    input  logic                       clear,
    input  logic signed [SUM_W-1:0]    sum_i,
    input  logic                       sum_valid_i,
    output logic                       sum_ready_o,
    output logic signed [SAMPLE_W-1:0] sample_o,
    output logic                       sample_valid_o,
    input  logic                       sample_ready_i,
    output logic                       overflow_o
);

    // Two guard bits keep S[n] - S[n-1] + x[n-N] exact for any input sums.
    localparam int DIFF_W = SUM_W + 2;

    logic                       flush;
    logic                       accept;
    logic signed [SUM_W-1:0]    prev_sum;
    logic signed [SAMPLE_W-1:0] hist_rd;
    logic signed [DIFF_W-1:0]   diff;
    logic [DIFF_W-SAMPLE_W:0]   diff_top;
    logic                       diff_ovf;

    assign flush       = system1000_rst | clear;
    assign sum_ready_o = !clear && (!sample_valid_o || sample_ready_i);
    assign accept      = sum_valid_i && sum_ready_o;

    assign diff = {{2{sum_i[SUM_W-1]}}, sum_i}
                - {{2{prev_sum[SUM_W-1]}}, prev_sum}
                + {{(DIFF_W-SAMPLE_W){hist_rd[SAMPLE_W-1]}}, hist_rd};

    // In range exactly when every bit from the sample sign bit upward agrees.
    assign diff_top = diff[DIFF_W-1:SAMPLE_W-1];
    assign diff_ovf = !((&diff_top) || !(|diff_top));

    moving_sum_deconv_ring #(
        .N        (N),
        .SAMPLE_W (SAMPLE_W)
    ) u_ring (
        .clk     (system1000),
        .flush   (flush),
        .adv     (accept),
        .wr_data (diff[SAMPLE_W-1:0]),
        .rd_data (hist_rd)
    );

    always_ff @(posedge system1000) begin
        if (flush) begin
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            overflow_o     <= 1'b0;
            prev_sum       <= '0;
        end else if (accept) begin
            sample_o       <= diff[SAMPLE_W-1:0];
            sample_valid_o <= 1'b1;
            prev_sum       <= sum_i;
            if (diff_ovf) begin
                overflow_o <= 1'b1;
            end
        end else if (sample_ready_i) begin
            sample_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_sum_deconvolver.sv
// Directed scenarios plus a randomized stream produced by a forward moving-sum
// model; every reconstructed sample must equal the sample that built the sum.
module tb_moving_sum_deconvolver;
    import moving_average_types::*;

    localparam int N  = N_DEFAULT;
    localparam int SW = SUM_W_DEFAULT;

    logic          system1000 = 1'b0;
    logic          system1000_rst = 1'b1;
    logic          clear = 1'b0;
    logic [SW-1:0] sum_i = '0;
    logic          sum_valid_i = 1'b0;
    logic          sum_ready_o;
    sample_t       sample_o;
    logic          sample_valid_o;
    logic          sample_ready_i = 1'b1;
    logic          overflow_o;

    int checks = 0;
    int errors = 0;
    bit rand_bp = 1'b0;
    logic [SAMPLE_W_DEFAULT-1:0] exp_q[$];

    moving_sum_deconvolver dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .clear          (clear),
        .sum_i          (sum_i),
        .sum_valid_i    (sum_valid_i),
        .sum_ready_o    (sum_ready_o),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .overflow_o     (overflow_o)
    );

    // clock / reset
    always #5 system1000 = ~system1000;

    function automatic logic [7:0] s8(input int v);
        return v[7:0];
    endfunction

    task automatic tick();
        @(posedge system1000);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        system1000_rst = 1'b1;
        tick();
        system1000_rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_bp) sample_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
    endtask

    // driver: offer one sum, hold it until taken (bounded)
    task automatic send(input int s);
        sum_i = s[SW-1:0];
        sum_valid_i = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (rand_bp) sample_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge system1000);
            if (sum_ready_o) begin
                tick();
                sum_valid_i = 1'b0;
                return;
            end
            tick();
        end
        sum_valid_i = 1'b0;
        checks++;
        errors++;
        $error("FAIL send_timeout sum=%0d not accepted within 64 cycles", s);
    endtask

    // send with expected sample; with ready held high also check one-cycle latency
    task automatic send_exp(input int s, input int x);
        exp_q.push_back(s8(x));
        send(s);
        if (!rand_bp) begin
            chk("latency_sample", $unsigned(sample_o), s8(x));
            chk("latency_valid", sample_valid_o, 1);
        end
    endtask

    // scoreboard: every output handoff must match the next expected sample
    always @(negedge system1000) begin
        if (sample_valid_o && sample_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_sample observed=%0d expected=none", sample_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                assert ($unsigned(sample_o) === e) else begin
                    errors++;
                    $error("FAIL sample observed=%0d expected=%0d", sample_o, $signed(e));
                end
            end
        end
    end

    initial begin
        int xq[$];
        int x;
        int s;

        // reset state
        do_reset();
        chk("rst_sample", $unsigned(sample_o), 0);
        chk("rst_valid", sample_valid_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_ready", sum_ready_o, 1);

        // basic stream
        send_exp(10, 10); send_exp(30, 20); send_exp(0, -30);
        send_exp(40, 40); send_exp(35, 5);
        chk("s1_ovf", overflow_o, 0);

        // pointer wraps twice
        do_reset();
        send_exp(1, 1); send_exp(2, 1); send_exp(3, 1);
        for (int i = 0; i < 6; i++) send_exp(4, 1);
        idle(1);
        chk("s2_idle_valid", sample_valid_o, 0);
        chk("s2_idle_hold", $unsigned(sample_o), s8(1));

        // overflow: 200 wraps to -56 and the flag sticks
        do_reset();
        send_exp(200, -56);
        chk("s3_ovf", overflow_o, 1);
        send_exp(200, 0);
        chk("s3_ovf_sticky", overflow_o, 1);

        // clear: continue from overflow state, then flush
        send_exp(10, 66);
        send_exp(30, 20);
        clear = 1'b1;
        sum_i = 10'd99;
        sum_valid_i = 1'b1;
        @(negedge system1000);
        chk("s5_clear_ready", sum_ready_o, 0);
        tick();
        clear = 1'b0;
        sum_valid_i = 1'b0;
        chk("s5_clear_valid", sample_valid_o, 0);
        chk("s5_clear_ovf", overflow_o, 0);
        chk("s5_clear_sample", $unsigned(sample_o), 0);
        send_exp(5, 5);
        chk("s5_ovf_after", overflow_o, 0);

        // backpressure holds output and blocks input
        do_reset();
        sample_ready_i = 1'b0;
        send_exp(10, 10);
        sum_i = 10'd30;
        sum_valid_i = 1'b1;
        tick();
        tick();
        chk("s4_hold_sample", $unsigned(sample_o), s8(10));
        chk("s4_hold_valid", sample_valid_o, 1);
        chk("s4_ready_low", sum_ready_o, 0);
        exp_q.push_back(s8(20));
        sample_ready_i = 1'b1;
        tick();
        sum_valid_i = 1'b0;
        chk("s4_next_sample", $unsigned(sample_o), s8(20));
        chk("s4_next_valid", sample_valid_o, 1);
        idle(1);

        // reset drops a stalled output
        do_reset();
        sample_ready_i = 1'b0;
        send(10);
        chk("s6_stalled_valid", sample_valid_o, 1);
        do_reset();
        chk("s6_rst_valid", sample_valid_o, 0);
        chk("s6_rst_sample", $unsigned(sample_o), 0);
        sample_ready_i = 1'b1;
        send_exp(10, 10); send_exp(30, 20); send_exp(0, -30);
        send_exp(40, 40); send_exp(35, 5);
        chk("s6_ovf", overflow_o, 0);

        // random stream from a forward window-sum model, random backpressure and gaps
        do_reset();
        rand_bp = 1'b1;
        for (int i = 0; i < N; i++) xq.push_back(0);
        for (int n = 0; n < 300; n++) begin
            if (n % 75 == 74) begin
                sample_ready_i = 1'b1;
                rand_bp = 1'b0;
                idle(3);
                chk("rnd_drained", exp_q.size(), 0);
                clear = 1'b1;
                tick();
                clear = 1'b0;
                xq.delete();
                for (int i = 0; i < N; i++) xq.push_back(0);
                rand_bp = 1'b1;
            end
            x = int'($urandom_range(0, 255)) - 128;
            xq.push_back(x);
            void'(xq.pop_front());
            s = 0;
            foreach (xq[i]) s += xq[i];
            exp_q.push_back(s8(x));
            send(s);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rand_bp = 1'b0;
        sample_ready_i = 1'b1;
        idle(4);
        chk("rnd_ovf", overflow_o, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
